// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch for the 8-bit CPU: fetches one byte per
// instruction, resolves conditional jumps locally and issues the rest to the decoder.
module fetch_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [7:0]        mem_data,
    input  logic              mem_rdy,
    output logic [2:0]        cond_opcode,
    input  logic              cond_result,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              branch_taken,
    output logic              halted,
    output logic [1:0]        state_dbg
);

    // Handshakes: mem_req/mem_addr stay stable in FETCH until a cycle with mem_rdy
    // high, which is the transfer; instr_valid/instr_out stay stable in ISSUE until
    // a cycle with instr_ack high, which is the transfer. Neither side may retract.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        BRANCH = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic [7:0]        ir, ir_next;
    logic              halt_pend, halt_pend_next;
    logic              stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_q      <= RESET_ADDR;
            ir        <= 8'h00;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            ir        <= ir_next;
            halt_pend <= halt_pend_next;
        end
    end

    // A halt seen anywhere inside an instruction is remembered until its boundary.
    assign stop = halt | halt_pend;

    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        ir_next        = ir;
        halt_pend_next = halt_pend | halt;
        mem_req        = 1'b0;
        instr_valid    = 1'b0;
        branch_taken   = 1'b0;
        halted         = 1'b0;
        case (state)
            IDLE: begin
                halted         = 1'b1;
                halt_pend_next = 1'b0;
                if (run && !halt) state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_next    = mem_data;
                    state_next = (mem_data[7:6] == 2'b11) ? BRANCH : ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    pc_next    = pc_q + ADDR_W'(1);
                    state_next = stop ? IDLE : FETCH;
                end
            end
            BRANCH: begin
                if (cond_result) begin
                    pc_next      = jump_target;
                    branch_taken = 1'b1;
                end else begin
                    pc_next = pc_q + ADDR_W'(1);
                end
                state_next = stop ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_out   = ir;
    assign cond_opcode = ir[2:0];
    assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each scenario task drives the handshakes
// cycle by cycle and compares outputs against hand-computed values.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, halt;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic [7:0] mem_data;
    logic       mem_rdy;
    logic [2:0] cond_opcode;
    logic       cond_result;
    logic [7:0] jump_target;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ack;
    logic [7:0] pc;
    logic       branch_taken;
    logic       halted;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    fetch_sequencer #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_rdy(mem_rdy),
        .cond_opcode(cond_opcode), .cond_result(cond_result), .jump_target(jump_target),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .pc(pc), .branch_taken(branch_taken), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; halt = 1'b0; mem_data = 8'h00; mem_rdy = 1'b0;
        cond_result = 1'b0; jump_target = 8'h00; instr_ack = 1'b0;
        #2;
        n_vec++; if (halted !== 1'b1) begin n_bad++; $display("FAIL reset_halted: got %b exp 1", halted); end
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        n_vec++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL reset_branch: got %b exp 0", branch_taken); end
        n_vec++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h exp 00", pc); end
        n_vec++; if (instr_out !== 8'h00) begin n_bad++; $display("FAIL reset_ir: got %h exp 00", instr_out); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (halted !== 1'b1) begin n_bad++; $display("FAIL idle_no_run: got %b exp 1", halted); end
    endtask

    task automatic test_basic_issue();
        run = 1'b1;
        tick();
        #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL basic_fetch0: got req=%b addr=%h exp req=1 addr=00", mem_req, mem_addr); end
        n_vec++; if (halted !== 1'b0) begin n_bad++; $display("FAIL basic_halted: got %b exp 0", halted); end
        mem_data = 8'h12; mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0; instr_ack = 1'b1;
        #1;
        n_vec++; if (instr_valid !== 1'b1 || instr_out !== 8'h12) begin n_bad++; $display("FAIL basic_issue: got valid=%b ir=%h exp valid=1 ir=12", instr_valid, instr_out); end
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop: got %b exp 0", mem_req); end
        tick();
        instr_ack = 1'b0;
        #1;
        n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b exp 0", instr_valid); end
        n_vec++; if (pc !== 8'h01 || mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_bad++; $display("FAIL basic_fetch1: got pc=%h req=%b addr=%h exp pc=01 req=1 addr=01", pc, mem_req, mem_addr); end
    endtask

    task automatic test_branch_always();
        mem_data = 8'hC4; mem_rdy = 1'b1; jump_target = 8'h40;
        tick();
        mem_rdy = 1'b0; cond_result = 1'b1;
        #1;
        n_vec++; if (cond_opcode !== 3'b100) begin n_bad++; $display("FAIL always_opcode: got %b exp 100", cond_opcode); end
        n_vec++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL always_quiet: got valid=%b req=%b exp 0 0", instr_valid, mem_req); end
        n_vec++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL always_taken: got %b exp 1", branch_taken); end
        tick();
        cond_result = 1'b0;
        #1;
        n_vec++; if (branch_taken !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL always_pulse: got taken=%b valid=%b exp 0 0", branch_taken, instr_valid); end
        n_vec++; if (pc !== 8'h40 || mem_addr !== 8'h40 || mem_req !== 1'b1) begin n_bad++; $display("FAIL always_pc: got pc=%h addr=%h req=%b exp 40 40 1", pc, mem_addr, mem_req); end
    endtask

    task automatic test_branch_never();
        // Jump to 5 first so the not-taken case starts at pc 5.
        mem_data = 8'hC4; mem_rdy = 1'b1; jump_target = 8'h05;
        tick();
        mem_rdy = 1'b0; cond_result = 1'b1;
        tick();
        cond_result = 1'b0;
        #1;
        n_vec++; if (pc !== 8'h05) begin n_bad++; $display("FAIL never_setup_pc: got %h exp 05", pc); end
        mem_data = 8'hC0; mem_rdy = 1'b1; jump_target = 8'h40;
        tick();
        mem_rdy = 1'b0; cond_result = 1'b0;
        #1;
        n_vec++; if (cond_opcode !== 3'b000 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL never_branch: got op=%b taken=%b exp 000 0", cond_opcode, branch_taken); end
        tick();
        #1;
        n_vec++; if (pc !== 8'h06 || mem_addr !== 8'h06 || mem_req !== 1'b1) begin n_bad++; $display("FAIL never_pc: got pc=%h addr=%h req=%b exp 06 06 1", pc, mem_addr, mem_req); end
    endtask

    task automatic test_wrap_and_selfloop();
        mem_data = 8'hC7; mem_rdy = 1'b1; jump_target = 8'hFF;
        tick();
        mem_rdy = 1'b0; cond_result = 1'b1;
        tick();
        cond_result = 1'b0;
        mem_data = 8'h01; mem_rdy = 1'b1;
        #1;
        n_vec++; if (pc !== 8'hFF) begin n_bad++; $display("FAIL wrap_setup_pc: got %h exp ff", pc); end
        tick();
        mem_rdy = 1'b0; instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        #1;
        n_vec++; if (pc !== 8'h00 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL wrap_pc: got pc=%h addr=%h exp 00 00", pc, mem_addr); end
        for (int i = 0; i < 2; i++) begin
            mem_data = 8'hC7; mem_rdy = 1'b1; jump_target = 8'h00;
            tick();
            mem_rdy = 1'b0; cond_result = 1'b1;
            #1;
            n_vec++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL selfloop_taken%0d: got %b exp 1", i, branch_taken); end
            tick();
            cond_result = 1'b0;
            #1;
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL selfloop_refetch%0d: got req=%b addr=%h exp 1 00", i, mem_req, mem_addr); end
        end
    endtask

    task automatic test_stalls();
        // Stray ack while waiting on memory must be ignored.
        mem_rdy = 1'b0; instr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc !== 8'h00) begin n_bad++; $display("FAIL stall_fetch%0d: got req=%b addr=%h pc=%h exp 1 00 00", i, mem_req, mem_addr, pc); end
        end
        instr_ack = 1'b0; mem_data = 8'h2A; mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0; mem_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (instr_valid !== 1'b1 || instr_out !== 8'h2A || pc !== 8'h00) begin n_bad++; $display("FAIL stall_issue%0d: got valid=%b ir=%h pc=%h exp 1 2a 00", i, instr_valid, instr_out, pc); end
            tick();
        end
        instr_ack = 1'b1;
        #1;
        n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_ack_valid: got %b exp 1", instr_valid); end
        tick();
        instr_ack = 1'b0;
        #1;
        n_vec++; if (pc !== 8'h01 || mem_req !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL stall_advance: got pc=%h req=%b valid=%b exp 01 1 0", pc, mem_req, instr_valid); end
    endtask

    task automatic test_halt_resume();
        mem_rdy = 1'b0; halt = 1'b1; run = 1'b0;
        tick();
        halt = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b1 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_no_abort: got req=%b halted=%b exp 1 0", mem_req, halted); end
        mem_data = 8'h33; mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0; instr_ack = 1'b1;
        #1;
        n_vec++; if (instr_valid !== 1'b1 || instr_out !== 8'h33) begin n_bad++; $display("FAIL halt_completes: got valid=%b ir=%h exp 1 33", instr_valid, instr_out); end
        tick();
        instr_ack = 1'b0;
        tick();
        #1;
        n_vec++; if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h02) begin n_bad++; $display("FAIL halt_idle: got halted=%b req=%b pc=%h exp 1 0 02", halted, mem_req, pc); end
        run = 1'b1;
        tick();
        #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h02 || halted !== 1'b0) begin n_bad++; $display("FAIL resume_pc: got req=%b addr=%h halted=%b exp 1 02 0", mem_req, mem_addr, halted); end
        // halt arriving together with mem_rdy: capture, complete, then stop.
        mem_data = 8'h55; mem_rdy = 1'b1; halt = 1'b1;
        tick();
        mem_rdy = 1'b0; halt = 1'b0; instr_ack = 1'b1;
        #1;
        n_vec++; if (instr_out !== 8'h55 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_halt_capture: got ir=%h valid=%b exp 55 1", instr_out, instr_valid); end
        tick();
        instr_ack = 1'b0;
        #1;
        n_vec++; if (halted !== 1'b1 || pc !== 8'h03) begin n_bad++; $display("FAIL rdy_halt_idle: got halted=%b pc=%h exp 1 03", halted, pc); end
        tick();
        #1;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 8'h03) begin n_bad++; $display("FAIL rdy_halt_resume: got req=%b addr=%h exp 1 03", mem_req, mem_addr); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL areset_ctrl: got req=%b halted=%b valid=%b exp 0 1 0", mem_req, halted, instr_valid); end
        n_vec++; if (pc !== 8'h00 || instr_out !== 8'h00 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL areset_regs: got pc=%h ir=%h taken=%b exp 00 00 0", pc, instr_out, branch_taken); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_branch_always();
        test_branch_never();
        test_wrap_and_selfloop();
        test_stalls();
        test_halt_resume();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
